// File: rtl/arb_refresh_sdr_16.sv
// Front-end scheduler for the 16-bit SDR SDRAM command FSM.
// Round-robin grant of the FSM request interface across the egress FIFOs.
// Grants move only while the FSM idles. Also schedules periodic auto-refresh
// and counts the refreshes still owed to the device.
module arb_refresh_sdr_16 #(
    parameter int nr_of_ports         = 4,
    parameter int refresh_period      = 390,
    parameter int refresh_pending_max = 7
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [nr_of_ports-1:0] fifo_empty_i,
    input  logic                   fifo_rd_adr_i,
    input  logic                   fifo_rd_data_i,
    input  logic                   state_idle,
    input  logic                   cmd_aref,
    output logic                   fifo_empty_o,
    output logic [nr_of_ports-1:0] fifo_sel_o,
    output logic [nr_of_ports-1:0] fifo_rd_adr_o,
    output logic [nr_of_ports-1:0] fifo_rd_data_o,
    output logic                   refresh_req
);

    localparam int GNT_W  = (nr_of_ports > 1) ? $clog2(nr_of_ports) : 1;
    localparam int TMR_W  = (refresh_period > 1) ? $clog2(refresh_period) : 1;
    localparam int PEND_W = $clog2(refresh_pending_max + 1);

    logic [GNT_W-1:0]  gnt;
    logic [GNT_W-1:0]  gnt_nxt;
    logic              gnt_vld;
    logic              served;
    logic              found;
    logic              arb_cycle;
    logic              accept;
    logic [TMR_W-1:0]  timer;
    logic              tick;
    logic [PEND_W-1:0] pending;

    // Decode the grant index into the one-hot select and the FSM-facing empty flag.
    always_comb begin
        fifo_sel_o = '0;
        for (int i = 0; i < nr_of_ports; i++) begin
            fifo_sel_o[i] = gnt_vld && (gnt == GNT_W'(i));
        end
        fifo_empty_o = ~gnt_vld | served | fifo_empty_i[gnt];
    end

    // A new grant is searched whenever the idle FSM has nothing valid to take.
    // A pending refresh blocks acceptance so the grant survives the refresh.
    always_comb begin
        arb_cycle = state_idle & fifo_empty_o;
        accept    = state_idle & ~refresh_req & ~fifo_empty_o;
    end

    // Round-robin search starting after the current grant and ending on it.
    always_comb begin
        logic [GNT_W-1:0] cand;
        gnt_nxt = gnt;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= nr_of_ports; k++) begin
            cand = GNT_W'((int'(gnt) + k) % nr_of_ports);
            if (!found && !fifo_empty_i[cand]) begin
                found   = 1'b1;
                gnt_nxt = cand;
            end
        end
    end

    // Grant register: updated on arb cycles, marked served when the FSM accepts.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            gnt     <= GNT_W'(nr_of_ports - 1);
            gnt_vld <= 1'b0;
            served  <= 1'b0;
        end else if (arb_cycle) begin
            served <= 1'b0;
            if (found) begin
                gnt     <= gnt_nxt;
                gnt_vld <= 1'b1;
            end else begin
                gnt_vld <= 1'b0;
            end
        end else if (accept) begin
            served <= 1'b1;
        end
    end

    // Read strobes only reach the granted port.
    always_comb begin
        fifo_rd_adr_o  = {nr_of_ports{fifo_rd_adr_i}} & fifo_sel_o;
        fifo_rd_data_o = {nr_of_ports{fifo_rd_data_i}} & fifo_sel_o;
    end

    // Tick on the last count of the free-running refresh interval.
    always_comb begin
        tick        = (timer == TMR_W'(refresh_period - 1));
        refresh_req = (pending != '0);
    end

    // Free-running refresh interval timer.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Saturating count of owed refreshes; an ack without a tick also covers init refreshes.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            pending <= '0;
        end else begin
            case ({tick, cmd_aref})
                2'b10: begin
                    if (pending != PEND_W'(refresh_pending_max)) begin
                        pending <= pending + 1'b1;
                    end
                end
                2'b01: begin
                    if (pending != '0) begin
                        pending <= pending - 1'b1;
                    end
                end
                default: begin
                    pending <= pending;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_refresh_sdr_16.sv
// Directed self-checking bench for arb_refresh_sdr_16 (4 ports, refresh period 10).
// Inputs change one time unit after the rising edge; outputs are checked
// after they have settled, well away from the next edge.
module tb_arb_refresh_sdr_16;

    localparam int NP = 4;

    logic          sdram_clk = 1'b0;
    logic          sdram_rst;
    logic [NP-1:0] fifo_empty_i;
    logic          fifo_rd_adr_i;
    logic          fifo_rd_data_i;
    logic          state_idle;
    logic          cmd_aref;
    logic          fifo_empty_o;
    logic [NP-1:0] fifo_sel_o;
    logic [NP-1:0] fifo_rd_adr_o;
    logic [NP-1:0] fifo_rd_data_o;
    logic          refresh_req;

    int checks = 0;
    int errors = 0;

    arb_refresh_sdr_16 #(
        .nr_of_ports        (NP),
        .refresh_period     (10),
        .refresh_pending_max(7)
    ) dut (
        .sdram_clk     (sdram_clk),
        .sdram_rst     (sdram_rst),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rd_adr_i (fifo_rd_adr_i),
        .fifo_rd_data_i(fifo_rd_data_i),
        .state_idle    (state_idle),
        .cmd_aref      (cmd_aref),
        .fifo_empty_o  (fifo_empty_o),
        .fifo_sel_o    (fifo_sel_o),
        .fifo_rd_adr_o (fifo_rd_adr_o),
        .fifo_rd_data_o(fifo_rd_data_o),
        .refresh_req   (refresh_req)
    );

    // Free-running 10-unit clock.
    always #5 sdram_clk = ~sdram_clk;

    // Hard upper bound on run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge sdram_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] empty, input logic idle, input logic aref,
                                 input logic rdAdr, input logic rdData);
        fifo_empty_i   = empty;
        state_idle     = idle;
        cmd_aref       = aref;
        fifo_rd_adr_i  = rdAdr;
        fifo_rd_data_i = rdData;
        #1;
    endtask

    task automatic doReset(input logic [NP-1:0] empty, input logic idle, input logic aref);
        sdram_rst = 1'b1;
        applyStimulus(empty, idle, aref, 1'b0, 1'b0);
        stepCycles(2);
        sdram_rst = 1'b0;
    endtask

    // Entered in a cycle where the grant should be visible and the FSM idles:
    // accept, run two busy cycles, return to idle for one arb cycle.
    task automatic runTransaction(input string tag, input logic [NP-1:0] expSel, input logic [NP-1:0] nextEmpty);
        checkOutput({tag, " sel"}, 32'(fifo_sel_o), 32'(expSel));
        checkOutput({tag, " empty_o"}, 32'(fifo_empty_o), 32'd0);
        stepCycles(1);
        applyStimulus(nextEmpty, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycles(2);
        applyStimulus(nextEmpty, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, " arb empty_o"}, 32'(fifo_empty_o), 32'd1);
        stepCycles(1);
    endtask

    initial begin
        // Reset values, with strobes held high to show they are blocked.
        sdram_rst = 1'b1;
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
        stepCycles(2);
        checkOutput("rst sel", 32'(fifo_sel_o), 32'd0);
        checkOutput("rst empty_o", 32'(fifo_empty_o), 32'd1);
        checkOutput("rst refresh_req", 32'(refresh_req), 32'd0);
        checkOutput("rst rd_adr_o", 32'(fifo_rd_adr_o), 32'd0);
        checkOutput("rst rd_data_o", 32'(fifo_rd_data_o), 32'd0);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        sdram_rst = 1'b0;

        // Refresh timer: ticks on edges 10, 20, 30 after release.
        stepCycles(9);
        checkOutput("ref edge9", 32'(refresh_req), 32'd0);
        stepCycles(1);
        checkOutput("ref edge10", 32'(refresh_req), 32'd1);
        stepCycles(20);
        checkOutput("ref edge30", 32'(refresh_req), 32'd1);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("ref pend3 after2acks", 32'(refresh_req), 32'd1);
        stepCycles(1);
        checkOutput("ref pend3 after3acks", 32'(refresh_req), 32'd0);
        stepCycles(3);
        checkOutput("ref ack at zero", 32'(refresh_req), 32'd0);
        stepCycles(4);
        checkOutput("ref tick+ack at zero", 32'(refresh_req), 32'd0);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(10);
        checkOutput("ref edge50", 32'(refresh_req), 32'd1);
        stepCycles(9);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("ref tick+ack held", 32'(refresh_req), 32'd1);
        stepCycles(1);
        checkOutput("ref tick+ack was 1", 32'(refresh_req), 32'd0);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(199);
        checkOutput("ref 20 ticks", 32'(refresh_req), 32'd1);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(6);
        checkOutput("ref sat after6acks", 32'(refresh_req), 32'd1);
        stepCycles(1);
        checkOutput("ref sat after7acks", 32'(refresh_req), 32'd0);

        // Single port 2, with strobe steering.
        doReset(4'hF, 1'b1, 1'b1);
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("single pre sel", 32'(fifo_sel_o), 32'd0);
        checkOutput("single pre empty_o", 32'(fifo_empty_o), 32'd1);
        stepCycles(1);
        checkOutput("single sel", 32'(fifo_sel_o), 32'b0100);
        checkOutput("single empty_o", 32'(fifo_empty_o), 32'd0);
        stepCycles(1);
        applyStimulus(4'b1011, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("single served empty_o", 32'(fifo_empty_o), 32'd1);
        checkOutput("single rd_adr_o", 32'(fifo_rd_adr_o), 32'b0100);
        checkOutput("single rd_data_o idle", 32'(fifo_rd_data_o), 32'd0);
        applyStimulus(4'b1011, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("single rd_data_o", 32'(fifo_rd_data_o), 32'b0100);
        checkOutput("single rd_adr_o idle", 32'(fifo_rd_adr_o), 32'd0);
        applyStimulus(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("single arb empty_o", 32'(fifo_empty_o), 32'd1);
        checkOutput("single arb sel", 32'(fifo_sel_o), 32'b0100);
        stepCycles(1);
        checkOutput("single regrant sel", 32'(fifo_sel_o), 32'b0100);
        checkOutput("single regrant empty_o", 32'(fifo_empty_o), 32'd0);

        // Round robin with all ports busy.
        doReset(4'b0000, 1'b1, 1'b1);
        stepCycles(1);
        runTransaction("rr0", 4'b0001, 4'b0000);
        runTransaction("rr1", 4'b0010, 4'b0000);
        runTransaction("rr2", 4'b0100, 4'b0000);
        runTransaction("rr3", 4'b1000, 4'b0000);
        runTransaction("rr4", 4'b0001, 4'b0000);

        // Self-wrap on port 3, then skip to 0 and on to 2.
        doReset(4'b0111, 1'b1, 1'b1);
        stepCycles(1);
        runTransaction("wrap3", 4'b1000, 4'b0111);
        runTransaction("wrap3 again", 4'b1000, 4'b1010);
        runTransaction("skip0", 4'b0001, 4'b1010);
        checkOutput("skip2 sel", 32'(fifo_sel_o), 32'b0100);

        // Grant stability while the FSM is busy.
        stepCycles(1);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stable a", 32'(fifo_sel_o), 32'b0100);
        stepCycles(1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stable b", 32'(fifo_sel_o), 32'b0100);
        stepCycles(1);
        applyStimulus(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stable c", 32'(fifo_sel_o), 32'b0100);
        stepCycles(1);
        applyStimulus(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stable d", 32'(fifo_sel_o), 32'b0100);
        stepCycles(1);
        checkOutput("stable e", 32'(fifo_sel_o), 32'b0100);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("all empty drop sel", 32'(fifo_sel_o), 32'd0);
        checkOutput("all empty empty_o", 32'(fifo_empty_o), 32'd1);

        // Refresh preemption of an idle grant on port 1.
        doReset(4'b1101, 1'b0, 1'b0);
        stepCycles(10);
        checkOutput("pre req", 32'(refresh_req), 32'd1);
        checkOutput("pre sel none", 32'(fifo_sel_o), 32'd0);
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("pre grant sel", 32'(fifo_sel_o), 32'b0010);
        checkOutput("pre grant empty_o", 32'(fifo_empty_o), 32'd0);
        stepCycles(2);
        checkOutput("pre held empty_o", 32'(fifo_empty_o), 32'd0);
        checkOutput("pre held req", 32'(refresh_req), 32'd1);
        applyStimulus(4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("pre drained req", 32'(refresh_req), 32'd0);
        checkOutput("pre drained sel", 32'(fifo_sel_o), 32'b0010);
        checkOutput("pre drained empty_o", 32'(fifo_empty_o), 32'd0);
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("pre accepted empty_o", 32'(fifo_empty_o), 32'd1);
        checkOutput("pre accepted sel", 32'(fifo_sel_o), 32'b0010);

        // Asynchronous reset mid-cycle clears the grant at once.
        stepCycles(1);
        applyStimulus(4'b1101, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("async pre rd_adr_o", 32'(fifo_rd_adr_o), 32'b0010);
        #2;
        sdram_rst = 1'b1;
        #1;
        checkOutput("async sel", 32'(fifo_sel_o), 32'd0);
        checkOutput("async empty_o", 32'(fifo_empty_o), 32'd1);
        checkOutput("async rd_adr_o", 32'(fifo_rd_adr_o), 32'd0);
        checkOutput("async req", 32'(refresh_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
